// File: rtl/tx_arb_pkg.sv
// Shared types for the TX frame arbiter: FSM states, source IDs and the
// round-robin grant function used by both IDLE and end-of-frame arbitration.
package tx_arb_pkg;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      SEND_RD     = 2'd1,
      SEND_ALU_LO = 2'd2,
      SEND_ALU_HI = 2'd3
   } arb_state_e;

   // Source IDs double as OVF bit indices.
   typedef enum logic {
      SRC_RD  = 1'b0,
      SRC_ALU = 1'b1
   } src_e;

   localparam int OVF_RD_BIT  = 0;
   localparam int OVF_ALU_BIT = 1;

   function automatic arb_state_e grant_state(input logic rd_full,
                                              input logic alu_full,
                                              input src_e last_grant);
      arb_state_e nxt;
      if (rd_full && alu_full) begin
         nxt = (last_grant == SRC_RD) ? SEND_ALU_LO : SEND_RD;
      end else if (rd_full) begin
         nxt = SEND_RD;
      end else if (alu_full) begin
         nxt = SEND_ALU_LO;
      end else begin
         nxt = IDLE;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/tx_frame_arbiter_frame_slot.sv
// One-entry holding slot for a result source. A load is accepted when the
// slot is empty or is being freed in the same cycle; otherwise it overruns.
module frame_slot #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             free,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             full,
   output logic             full_nxt,
   output logic             overrun
);

   logic [WIDTH-1:0] data_q, data_d;
   logic             full_q, full_d;
   logic             accept;

   always_comb begin
      accept = load && (!full_q || free);
      data_d = data_q;
      full_d = full_q;
      if (accept) begin
         data_d = data_in;
         full_d = 1'b1;
      end else if (free) begin
         full_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
         full_q <= 1'b0;
      end else begin
         data_q <= data_d;
         full_q <= full_d;
      end
   end

   assign data_out = data_q;
   assign full     = full_q;
   assign full_nxt = full_d;
   assign overrun  = load && !accept;

endmodule

// File: rtl/tx_frame_arbiter.sv
// Captures RD (byte) and ALU (two-byte) results into slots and serialises
// them round-robin onto the FIFO write port, stalling on FIFO_FULL.
//
// state       | meaning
// IDLE        | no frame in progress, waiting for a full slot
// SEND_RD     | writing the RD slot byte
// SEND_ALU_LO | writing ALU result low byte
// SEND_ALU_HI | writing ALU result high byte, frees ALU slot on write
module tx_frame_arbiter
   import tx_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                    CLK,
   input  logic                    RST_n,
   input  logic                    RD_VALID,
   input  logic [DATA_WIDTH-1:0]   RD_DATA,
   input  logic                    ALU_VALID,
   input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
   input  logic                    FIFO_FULL,
   input  logic                    OVF_CLR,
   output logic                    WR_INC,
   output logic [DATA_WIDTH-1:0]   WR_DATA,
   output logic                    BUSY,
   output logic [1:0]              OVF
);

   arb_state_e state_q, state_d;
   src_e       last_grant_q, last_grant_d;
   logic [1:0] ovf_q, ovf_d;

   logic                    rd_full, rd_full_nxt, rd_ovr, rd_free;
   logic                    alu_full, alu_full_nxt, alu_ovr, alu_free;
   logic [DATA_WIDTH-1:0]   rd_data;
   logic [2*DATA_WIDTH-1:0] alu_data;
   logic                    wr_inc;
   logic [DATA_WIDTH-1:0]   wr_data;

   frame_slot #(.WIDTH(DATA_WIDTH)) u_rd_slot (
      .clk      (CLK),
      .rst_n    (RST_n),
      .load     (RD_VALID),
      .free     (rd_free),
      .data_in  (RD_DATA),
      .data_out (rd_data),
      .full     (rd_full),
      .full_nxt (rd_full_nxt),
      .overrun  (rd_ovr)
   );

   frame_slot #(.WIDTH(2*DATA_WIDTH)) u_alu_slot (
      .clk      (CLK),
      .rst_n    (RST_n),
      .load     (ALU_VALID),
      .free     (alu_free),
      .data_in  (ALU_OUT),
      .data_out (alu_data),
      .full     (alu_full),
      .full_nxt (alu_full_nxt),
      .overrun  (alu_ovr)
   );

   assign wr_inc   = (state_q != IDLE) && !FIFO_FULL;
   assign rd_free  = wr_inc && (state_q == SEND_RD);
   assign alu_free = wr_inc && (state_q == SEND_ALU_HI);

   // End-of-frame arbitration looks at post-edge slot occupancy so the next
   // frame starts without an IDLE bubble.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      wr_data      = '0;
      case (state_q)
         IDLE: begin
            state_d = grant_state(rd_full, alu_full, last_grant_q);
         end
         SEND_RD: begin
            wr_data = rd_data;
            if (wr_inc) begin
               last_grant_d = SRC_RD;
               state_d      = grant_state(rd_full_nxt, alu_full_nxt, SRC_RD);
            end
         end
         SEND_ALU_LO: begin
            wr_data = alu_data[DATA_WIDTH-1:0];
            if (wr_inc) begin
               state_d = SEND_ALU_HI;
            end
         end
         SEND_ALU_HI: begin
            wr_data = alu_data[2*DATA_WIDTH-1:DATA_WIDTH];
            if (wr_inc) begin
               last_grant_d = SRC_ALU;
               state_d      = grant_state(rd_full_nxt, alu_full_nxt, SRC_ALU);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // A new overrun wins over a simultaneous clear.
   always_comb begin
      ovf_d = ovf_q;
      if (OVF_CLR) begin
         ovf_d = 2'b00;
      end
      if (rd_ovr) begin
         ovf_d[OVF_RD_BIT] = 1'b1;
      end
      if (alu_ovr) begin
         ovf_d[OVF_ALU_BIT] = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state_q      <= IDLE;
         last_grant_q <= SRC_ALU;
         ovf_q        <= 2'b00;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         ovf_q        <= ovf_d;
      end
   end

   assign WR_INC  = wr_inc;
   assign WR_DATA = wr_data;
   assign BUSY    = (state_q != IDLE) || rd_full || alu_full;
   assign OVF     = ovf_q;

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Directed bench for tx_frame_arbiter: per-cycle vector table plus a
// hand-written mid-frame reset sequence.
module tb_tx_frame_arbiter;

   logic        clk;
   logic        rst_n;
   logic        rd_valid;
   logic [7:0]  rd_data;
   logic        alu_valid;
   logic [15:0] alu_out;
   logic        fifo_full;
   logic        ovf_clr;
   logic        wr_inc;
   logic [7:0]  wr_data;
   logic        busy;
   logic [1:0]  ovf;

   int total;
   int bad;

   typedef struct {
      logic        rd_v;
      logic [7:0]  rd_d;
      logic        alu_v;
      logic [15:0] alu_d;
      logic        ff;
      logic        clr;
      logic        e_wr;
      logic [7:0]  e_data;
      logic        e_busy;
      logic [1:0]  e_ovf;
   } vec_t;

   vec_t vecs[$];

   tx_frame_arbiter #(.DATA_WIDTH(8)) dut (
      .CLK       (clk),
      .RST_n     (rst_n),
      .RD_VALID  (rd_valid),
      .RD_DATA   (rd_data),
      .ALU_VALID (alu_valid),
      .ALU_OUT   (alu_out),
      .FIFO_FULL (fifo_full),
      .OVF_CLR   (ovf_clr),
      .WR_INC    (wr_inc),
      .WR_DATA   (wr_data),
      .BUSY      (busy),
      .OVF       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic add(input logic rv, input logic [7:0] rdd, input logic av,
                      input logic [15:0] ad, input logic ff, input logic clr,
                      input logic ew, input logic [7:0] ed, input logic eb,
                      input logic [1:0] eo);
      vec_t v;
      v.rd_v = rv;  v.rd_d = rdd; v.alu_v = av; v.alu_d = ad;
      v.ff = ff;    v.clr = clr;  v.e_wr = ew;  v.e_data = ed;
      v.e_busy = eb; v.e_ovf = eo;
      vecs.push_back(v);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      total = 0;
      bad   = 0;

      // One entry per cycle: inputs driven that cycle, outputs seen that cycle.
      // Single RD byte.
      add(1,8'hA5,0,16'h0,0,0, 0,8'h00,0,2'd0);
      add(0,8'h00,0,16'h0,0,0, 0,8'h00,1,2'd0);
      add(0,8'h00,0,16'h0,0,0, 1,8'hA5,1,2'd0);
      add(0,8'h00,0,16'h0,0,0, 0,8'h00,0,2'd0);
      // Single ALU frame.
      add(0,8'h00,1,16'h1234,0,0, 0,8'h00,0,2'd0);
      add(0,8'h00,0,16'h0,0,0, 0,8'h00,1,2'd0);
      add(0,8'h00,0,16'h0,0,0, 1,8'h34,1,2'd0);
      add(0,8'h00,0,16'h0,0,0, 1,8'h12,1,2'd0);
      add(0,8'h00,0,16'h0,0,0, 0,8'h00,0,2'd0);
      // Tie with last_grant=ALU: RD first.
      add(1,8'h11,1,16'hBEEF,0,0, 0,8'h00,0,2'd0);
      add(0,8'h00,0,16'h0,0,0, 0,8'h00,1,2'd0);
      add(0,8'h00,0,16'h0,0,0, 1,8'h11,1,2'd0);
      add(0,8'h00,0,16'h0,0,0, 1,8'hEF,1,2'd0);
      add(0,8'h00,0,16'h0,0,0, 1,8'hBE,1,2'd0);
      add(0,8'h00,0,16'h0,0,0, 0,8'h00,0,2'd0);
      // Lone RD makes last_grant=RD, so the next tie goes to ALU.
      add(1,8'h33,0,16'h0,0,0, 0,8'h00,0,2'd0);
      add(0,8'h00,0,16'h0,0,0, 0,8'h00,1,2'd0);
      add(0,8'h00,0,16'h0,0,0, 1,8'h33,1,2'd0);
      add(1,8'h44,1,16'h5566,0,0, 0,8'h00,0,2'd0);
      add(0,8'h00,0,16'h0,0,0, 0,8'h00,1,2'd0);
      add(0,8'h00,0,16'h0,0,0, 1,8'h66,1,2'd0);
      add(0,8'h00,0,16'h0,0,0, 1,8'h55,1,2'd0);
      add(0,8'h00,0,16'h0,0,0, 1,8'h44,1,2'd0);
      // Reload in the freeing cycle: accepted, no bubble, no OVF.
      add(1,8'h77,0,16'h0,0,0, 0,8'h00,0,2'd0);
      add(0,8'h00,0,16'h0,0,0, 0,8'h00,1,2'd0);
      add(1,8'h88,0,16'h0,0,0, 1,8'h77,1,2'd0);
      add(0,8'h00,0,16'h0,0,0, 1,8'h88,1,2'd0);
      add(0,8'h00,0,16'h0,0,0, 0,8'h00,0,2'd0);
      // FIFO_FULL for 5 cycles while in SEND_ALU_HI.
      add(0,8'h00,1,16'h1234,0,0, 0,8'h00,0,2'd0);
      add(0,8'h00,0,16'h0,0,0, 0,8'h00,1,2'd0);
      add(0,8'h00,0,16'h0,0,0, 1,8'h34,1,2'd0);
      for (int k = 0; k < 5; k++) add(0,8'h00,0,16'h0,1,0, 0,8'h12,1,2'd0);
      add(0,8'h00,0,16'h0,0,0, 1,8'h12,1,2'd0);
      add(0,8'h00,0,16'h0,0,0, 0,8'h00,0,2'd0);
      // RD overrun under FIFO_FULL, then clear.
      add(1,8'h11,0,16'h0,1,0, 0,8'h00,0,2'd0);
      add(0,8'h00,0,16'h0,1,0, 0,8'h00,1,2'd0);
      add(1,8'h22,0,16'h0,1,0, 0,8'h11,1,2'd0);
      add(0,8'h00,0,16'h0,1,0, 0,8'h11,1,2'd1);
      add(0,8'h00,0,16'h0,0,0, 1,8'h11,1,2'd1);
      add(0,8'h00,0,16'h0,0,1, 0,8'h00,0,2'd1);
      // Overrun coinciding with OVF_CLR keeps the bit set.
      add(1,8'h55,0,16'h0,1,0, 0,8'h00,0,2'd0);
      add(0,8'h00,0,16'h0,1,0, 0,8'h00,1,2'd0);
      add(1,8'h66,0,16'h0,1,1, 0,8'h55,1,2'd0);
      add(0,8'h00,0,16'h0,0,0, 1,8'h55,1,2'd1);
      add(0,8'h00,0,16'h0,0,1, 0,8'h00,0,2'd1);
      // ALU overrun sets bit1.
      add(0,8'h00,1,16'h0102,1,0, 0,8'h00,0,2'd0);
      add(0,8'h00,0,16'h0,1,0, 0,8'h00,1,2'd0);
      add(0,8'h00,1,16'h0304,1,0, 0,8'h02,1,2'd0);
      add(0,8'h00,0,16'h0,0,0, 1,8'h02,1,2'd2);
      add(0,8'h00,0,16'h0,0,0, 1,8'h01,1,2'd2);
      add(0,8'h00,0,16'h0,0,1, 0,8'h00,0,2'd2);
      add(0,8'h00,0,16'h0,0,0, 0,8'h00,0,2'd0);

      rst_n     = 1'b0;
      rd_valid  = 1'b0;
      rd_data   = '0;
      alu_valid = 1'b0;
      alu_out   = '0;
      fifo_full = 1'b0;
      ovf_clr   = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_wr_inc", 16'(wr_inc), 16'h0);
      check("rst_wr_data", 16'(wr_data), 16'h0);
      check("rst_busy", 16'(busy), 16'h0);
      check("rst_ovf", 16'(ovf), 16'h0);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         @(posedge clk);
         #1;
         rd_valid  = vecs[i].rd_v;
         rd_data   = vecs[i].rd_d;
         alu_valid = vecs[i].alu_v;
         alu_out   = vecs[i].alu_d;
         fifo_full = vecs[i].ff;
         ovf_clr   = vecs[i].clr;
         @(negedge clk);
         check($sformatf("v%0d_wr_inc", i), 16'(wr_inc), 16'(vecs[i].e_wr));
         check($sformatf("v%0d_wr_data", i), 16'(wr_data), 16'(vecs[i].e_data));
         check($sformatf("v%0d_busy", i), 16'(busy), 16'(vecs[i].e_busy));
         check($sformatf("v%0d_ovf", i), 16'(ovf), 16'(vecs[i].e_ovf));
      end

      // Reset after the ALU LO byte has been written.
      @(posedge clk);
      #1;
      rd_valid  = 1'b0;
      fifo_full = 1'b0;
      ovf_clr   = 1'b0;
      alu_valid = 1'b1;
      alu_out   = 16'hABCD;
      @(posedge clk);
      #1;
      alu_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("mr_lo_wr_inc", 16'(wr_inc), 16'h1);
      check("mr_lo_data", 16'(wr_data), 16'h00CD);
      @(posedge clk);
      #1;
      check("mr_hi_data", 16'(wr_data), 16'h00AB);
      rst_n = 1'b0;
      #1;
      check("mr_rst_wr_inc", 16'(wr_inc), 16'h0);
      check("mr_rst_wr_data", 16'(wr_data), 16'h0);
      check("mr_rst_busy", 16'(busy), 16'h0);
      check("mr_rst_ovf", 16'(ovf), 16'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         check($sformatf("mr_post%0d_wr_inc", c), 16'(wr_inc), 16'h0);
         check($sformatf("mr_post%0d_busy", c), 16'(busy), 16'h0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
